updown_counter_param: RTL and testbench
=======================================

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter, preset, limit and step width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0: value loaded into the count register on reset.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port enable, input, 1 bit: count enable; when low, the count holds (load still honoured).
REQ-006 The block SHALL have port load, input, 1 bit: synchronous load of preset.
REQ-007 The block SHALL have port preset, input, WIDTH bits: load value.
REQ-008 The block SHALL have port up, input, 1 bit: count-up request.
REQ-009 The block SHALL have port down, input, 1 bit: count-down request.
REQ-010 The block SHALL have port step, input, WIDTH bits: increment/decrement magnitude, unsigned.
REQ-011 The block SHALL have port limit_lo, input, WIDTH bits: lower count bound, unsigned.
REQ-012 The block SHALL have port limit_hi, input, WIDTH bits: upper count bound, unsigned.
REQ-013 The block SHALL have port sat_mode, input, 1 bit: 1 = saturate at bounds, 0 = wrap to opposite bound.
REQ-014 The block SHALL have port Q_out, output, WIDTH bits: registered count value.
REQ-015 The block SHALL have port tc_pulse, output, 1 bit: registered one-cycle pulse on bound crossing (wrap or clip).
REQ-016 The block SHALL have port at_hi, output, 1 bit: Q_out == limit_hi (combinational from register).
REQ-017 The block SHALL have port at_lo, output, 1 bit: Q_out == limit_lo (combinational from register).
REQ-018 The block SHALL have port limit_err, output, 1 bit: registered; high while limit_lo > limit_hi.

Function
REQ-019 Per-edge priority SHALL be: load > (enable & up & ~down) > (enable & down & ~up) > hold.
REQ-020 up and down both high, or both low, SHALL hold the count (no implicit decrement).
REQ-021 load SHALL set Q_out = preset next edge regardless of enable, limits or limit_err; tc_pulse = 0 that cycle.
REQ-022 Up-count arithmetic SHALL be WIDTH+1 bits: sum = Q_out + step; if sum <= limit_hi then next = sum, tc_pulse = 0.
REQ-023 Up-count with sum > limit_hi SHALL give next = limit_hi (sat_mode=1) or limit_lo (sat_mode=0), and tc_pulse = 1.
REQ-024 Down-count SHALL compute diff = Q_out - step with borrow; if no borrow and diff >= limit_lo then next = diff, tc_pulse = 0.
REQ-025 Down-count with borrow or diff < limit_lo SHALL give next = limit_lo (sat_mode=1) or limit_hi (sat_mode=0), and tc_pulse = 1.
REQ-026 Saturated hold at a bound (e.g. Q_out == limit_hi, up, sat_mode=1) SHALL pulse tc_pulse every such cycle only if step != 0.
REQ-027 step = 0 SHALL leave the count unchanged and tc_pulse = 0 unless Q_out is already outside [limit_lo, limit_hi].
REQ-028 A count outside bounds (after load) SHALL be clipped or wrapped per REQ-022..025 on the next count edge.
REQ-029 limit_err SHALL register (limit_lo > limit_hi) every edge; while set, count requests SHALL hold and tc_pulse = 0.
REQ-030 tc_pulse SHALL be low on every cycle not described in REQ-023/025/026/027.
REQ-031 Limits, step and sat_mode SHALL be sampled on the same edge as the count request; no latency beyond one edge.

Reset
REQ-032 clear low SHALL asynchronously force Q_out = RESET_VAL, tc_pulse = 0, limit_err = 0, independent of clock.
REQ-033 clear SHALL override load and count requests; the first active edge after clear rises SHALL perform normal operation.
REQ-034 clear asserted mid-count SHALL discard the pending update; no partial state SHALL survive.

Verification
REQ-035 WIDTH=8, lo=0, hi=255, step=1, sat_mode=0, Q=255, up -> Q=0, tc_pulse=1 for one cycle.
REQ-036 lo=10, hi=20, step=3, sat_mode=1, Q=19, up -> Q=20, tc_pulse=1; next up -> Q=20, tc_pulse=1; at_hi=1.
REQ-037 lo=10, hi=20, step=4, sat_mode=0, Q=12, down -> Q=20, tc_pulse=1; down -> Q=16, tc_pulse=0.
REQ-038 load=1, up=1, preset=0x5A -> Q=0x5A; up=down=1 for 3 edges -> Q stays 0x5A; enable=0, up -> Q stays.
REQ-039 lo=30, hi=5, up -> limit_err=1, Q unchanged; load preset=7 -> Q=7 despite limit_err.
REQ-040 Counting up, clear pulsed low between edges -> Q=RESET_VAL immediately; after release, count resumes from RESET_VAL.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: loadable up/down counter with programmable step
// and bounds; saturates or wraps at the limits and flags bound crossings.
module updown_counter_param #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] preset,
   input  logic             up,
   input  logic             down,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit_lo,
   input  logic [WIDTH-1:0] limit_hi,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] Q_out,
   output logic             tc_pulse,
   output logic             at_hi,
   output logic             at_lo,
   output logic             limit_err
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             err_q, err_d;
   logic [WIDTH:0]   sum, diff;
   logic             do_up, do_dn;
   logic             up_ovf, dn_unf;

   // Inverted limits block counting on the same edge they appear.
   assign err_d = limit_lo > limit_hi;
   assign do_up = ~load & enable & up & ~down & ~err_d;
   assign do_dn = ~load & enable & down & ~up & ~err_d;

   // One extra bit keeps the carry and the borrow visible.
   assign sum    = {1'b0, cnt_q} + {1'b0, step};
   assign diff   = {1'b0, cnt_q} - {1'b0, step};
   assign up_ovf = sum > {1'b0, limit_hi};
   assign dn_unf = diff[WIDTH] | (diff[WIDTH-1:0] < limit_lo);

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      unique case (1'b1)
         load: cnt_d = preset;
         do_up: begin
            if (up_ovf) begin
               cnt_d = sat_mode ? limit_hi : limit_lo;
               tc_d  = 1'b1;
            end else begin
               cnt_d = sum[WIDTH-1:0];
            end
         end
         do_dn: begin
            if (dn_unf) begin
               cnt_d = sat_mode ? limit_lo : limit_hi;
               tc_d  = 1'b1;
            end else begin
               cnt_d = diff[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt_q <= RESET_VAL;
         tc_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         err_q <= err_d;
      end
   end

   assign Q_out     = cnt_q;
   assign tc_pulse  = tc_q;
   assign limit_err = err_q;
   assign at_hi     = cnt_q == limit_hi;
   assign at_lo     = cnt_q == limit_lo;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed vectors feed a scoreboard queue;
// a monitor pops and compares after every clock edge or clear assertion.
module tb_updown_counter_param;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic [7:0] preset = '0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic [7:0] step = 8'd1;
   logic [7:0] limit_lo = 8'd0;
   logic [7:0] limit_hi = 8'd255;
   logic       sat_mode = 1'b0;
   logic [7:0] Q_out;
   logic       tc_pulse;
   logic       at_hi;
   logic       at_lo;
   logic       limit_err;

   typedef struct {
      string      nm;
      logic [7:0] q;
      bit         tc;
      bit         ahi;
      bit         alo;
      bit         err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   localparam logic [7:0] RV = 8'h03;

   updown_counter_param #(
      .WIDTH    (8),
      .RESET_VAL(RV)
   ) dut (
      .clock    (clock),
      .clear    (clear),
      .enable   (enable),
      .load     (load),
      .preset   (preset),
      .up       (up),
      .down     (down),
      .step     (step),
      .limit_lo (limit_lo),
      .limit_hi (limit_hi),
      .sat_mode (sat_mode),
      .Q_out    (Q_out),
      .tc_pulse (tc_pulse),
      .at_hi    (at_hi),
      .at_lo    (at_lo),
      .limit_err(limit_err)
   );

   always #5 clock = ~clock;

   task automatic push(input string nm, input logic [7:0] q,
                       input bit tc, input bit err);
      exp_t e;
      e.nm  = nm;
      e.q   = q;
      e.tc  = tc;
      e.ahi = (q == limit_hi);
      e.alo = (q == limit_lo);
      e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input string nm, input bit en, input bit ld,
                      input logic [7:0] pre, input bit u, input bit d,
                      input logic [7:0] stp, input logic [7:0] lo,
                      input logic [7:0] hi, input bit sat,
                      input logic [7:0] eq, input bit etc,
                      input bit eerr);
      @(negedge clock);
      enable   = en;
      load     = ld;
      preset   = pre;
      up       = u;
      down     = d;
      step     = stp;
      limit_lo = lo;
      limit_hi = hi;
      sat_mode = sat;
      push(nm, eq, etc, eerr);
   endtask

   // Clear pulsed between edges while the count request is still active.
   task automatic clr_pulse(input string nm);
      @(negedge clock);
      push(nm, RV, 1'b0, 1'b0);
      clear = 1'b0;
      #2;
      clear    = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      limit_lo = 8'd0;
      limit_hi = 8'd255;
      push({nm, "_hold"}, RV, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock or negedge clear);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (Q_out !== e.q || tc_pulse !== e.tc || at_hi !== e.ahi ||
                at_lo !== e.alo || limit_err !== e.err) begin
               n_bad++;
               $display("FAIL %s: got Q=%0d tc=%0b hi=%0b lo=%0b err=%0b, want Q=%0d tc=%0b hi=%0b lo=%0b err=%0b",
                        e.nm, Q_out, tc_pulse, at_hi, at_lo, limit_err,
                        e.q, e.tc, e.ahi, e.alo, e.err);
            end
         end
      end
   end

   initial begin : stim
      #2;
      push("reset", RV, 1'b0, 1'b0);
      clear = 1'b0;
      #20;
      clear = 1'b1;
      //   name          en ld pre    u  d  stp lo  hi   sat  Q     tc err
      cyc("ld255",       0, 1, 8'd255, 0, 0, 1, 0,  255, 0, 8'd255, 0, 0);
      cyc("wrap_up",     1, 0, 8'd0,  1, 0, 1, 0,  255, 0, 8'd0,   1, 0);
      cyc("up1",         1, 0, 8'd0,  1, 0, 1, 0,  255, 0, 8'd1,   0, 0);
      cyc("ld19",        0, 1, 8'd19, 0, 0, 3, 10, 20,  1, 8'd19,  0, 0);
      cyc("sat_hi",      1, 0, 8'd0,  1, 0, 3, 10, 20,  1, 8'd20,  1, 0);
      cyc("sat_hi2",     1, 0, 8'd0,  1, 0, 3, 10, 20,  1, 8'd20,  1, 0);
      cyc("step0_hi",    1, 0, 8'd0,  1, 0, 0, 10, 20,  1, 8'd20,  0, 0);
      cyc("ld12",        0, 1, 8'd12, 0, 0, 4, 10, 20,  0, 8'd12,  0, 0);
      cyc("wrap_dn",     1, 0, 8'd0,  0, 1, 4, 10, 20,  0, 8'd20,  1, 0);
      cyc("dn16",        1, 0, 8'd0,  0, 1, 4, 10, 20,  0, 8'd16,  0, 0);
      cyc("dn12",        1, 0, 8'd0,  0, 1, 4, 10, 20,  0, 8'd12,  0, 0);
      cyc("ld2",         0, 1, 8'd2,  0, 0, 5, 0,  255, 1, 8'd2,   0, 0);
      cyc("borrow_sat",  1, 0, 8'd0,  0, 1, 5, 0,  255, 1, 8'd0,   1, 0);
      cyc("ld2b",        0, 1, 8'd2,  0, 0, 5, 0,  255, 0, 8'd2,   0, 0);
      cyc("borrow_wrap", 1, 0, 8'd0,  0, 1, 5, 0,  255, 0, 8'd255, 1, 0);
      cyc("ld250",       0, 1, 8'd250, 0, 0, 10, 0, 255, 1, 8'd250, 0, 0);
      cyc("ovf9",        1, 0, 8'd0,  1, 0, 10, 0, 255, 1, 8'd255, 1, 0);
      cyc("ld50",        0, 1, 8'd50, 0, 0, 0, 10, 20,  1, 8'd50,  0, 0);
      cyc("oob_step0",   1, 0, 8'd0,  1, 0, 0, 10, 20,  1, 8'd20,  1, 0);
      cyc("ld50b",       0, 1, 8'd50, 0, 0, 1, 10, 20,  0, 8'd50,  0, 0);
      cyc("oob_wrap",    1, 0, 8'd0,  1, 0, 1, 10, 20,  0, 8'd10,  1, 0);
      cyc("ld_up5a",     1, 1, 8'h5A, 1, 0, 1, 0,  255, 0, 8'h5A,  0, 0);
      for (int i = 0; i < 3; i++)
         cyc("both",     1, 0, 8'd0,  1, 1, 1, 0,  255, 0, 8'h5A,  0, 0);
      cyc("en0",         0, 0, 8'd0,  1, 0, 1, 0,  255, 0, 8'h5A,  0, 0);
      cyc("none",        1, 0, 8'd0,  0, 0, 1, 0,  255, 0, 8'h5A,  0, 0);
      cyc("lim_err",     1, 0, 8'd0,  1, 0, 1, 30, 5,   0, 8'h5A,  0, 1);
      cyc("ld7_err",     0, 1, 8'd7,  0, 0, 1, 30, 5,   0, 8'd7,   0, 1);
      cyc("err_clr",     1, 0, 8'd0,  1, 0, 1, 0,  255, 0, 8'd8,   0, 0);
      cyc("err_set",     1, 0, 8'd0,  1, 0, 1, 30, 5,   0, 8'd8,   0, 1);
      clr_pulse("clr_err");
      cyc("ld254",       0, 1, 8'd254, 0, 0, 1, 0, 255, 0, 8'd254, 0, 0);
      cyc("up255",       1, 0, 8'd0,  1, 0, 1, 0,  255, 0, 8'd255, 0, 0);
      cyc("wrap0",       1, 0, 8'd0,  1, 0, 1, 0,  255, 0, 8'd0,   1, 0);
      clr_pulse("clr_tc");
      cyc("resume",      1, 0, 8'd0,  1, 0, 1, 0,  255, 0, RV + 8'd1, 0, 0);
      cyc("resume2",     1, 0, 8'd0,  1, 0, 1, 0,  255, 0, RV + 8'd2, 0, 0);
      repeat (2) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
